// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequencer for the 3-lane multiply-accumulate PE.
// Walks one output pixel's kernel (KROWS rows per channel over the configured
// channel count). It repeats that walk for each output pixel, driving the PE
// clear/finish controls, the operand gate and the buffer indices.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          one-cycle job request, accepted only in IDLE
//   cfg_channels   channels per pixel (0 treated as 1), latched on start
//   cfg_num_out    output pixels per job, latched on start
//   in_valid       buffer operands for the current indices are present
//   pe_en          PE accumulator clear (1 holds the PE sum at 0)
//   pe_finish      PE finish strobe, asserted on the final beat of a pixel
//   op_gate        1 feeds buffer operands to the PE, 0 feeds zeros
//   row_idx        current kernel row
//   ch_idx         current channel
//   pix_idx        current output pixel
//   wgt_addr       ch_idx*KROWS + row_idx
//   busy           high outside IDLE
//   done           one-cycle pulse at job end
//   stall_cnt      ACC cycles without operands (PE_SEQ_CTRL_PERF_EN only, else 0)
//
// Optional feature macro: PE_SEQ_CTRL_PERF_EN enables the stall counter.

module pe_seq_ctrl #(
  parameter int unsigned CH_W  = 8,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned KROWS = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CH_W-1:0]   cfg_channels,
  input  logic [OUT_W-1:0]  cfg_num_out,
  input  logic              in_valid,
  output logic              pe_en,
  output logic              pe_finish,
  output logic              op_gate,
  output logic [1:0]        row_idx,
  output logic [CH_W-1:0]   ch_idx,
  output logic [OUT_W-1:0]  pix_idx,
  output logic [CH_W+1:0]   wgt_addr,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned ROW_W   = 2;
  localparam int unsigned ADDR_W  = CH_W + 2;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_d;
  logic [CH_W-1:0]     ch_d;
  logic [OUT_W-1:0]    pix_d;
  logic [CH_W-1:0]     ch_last_q, ch_last_d;
  logic [OUT_W-1:0]    pix_last_q, pix_last_d;
  logic                pe_en_d, busy_d, done_d;
  logic [ADDR_W-1:0]   wgt_addr_d;
  logic                start_acc;
  logic                row_wrap, ch_wrap, last_beat;

  // Limits are latched as last-index values so every counter compares with ==.
  assign start_acc = (state_q == IDLE) && start;
  assign row_wrap  = (row_idx == ROW_W'(KROWS - 1));
  assign ch_wrap   = (ch_idx == ch_last_q);
  assign last_beat = row_wrap && ch_wrap;

  // Operand gate: the only intended path from in_valid to an output.
  assign op_gate   = (state_q == ACC) && in_valid;
  // Finish is qualified by the beat actually completing, so a stall on the
  // last row cannot close the pixel with a partial sum.
  assign pe_finish = op_gate && last_beat;

  // Next-state, next-index and next-output decode.
  always_comb begin
    state_d    = state_q;
    row_d      = row_idx;
    ch_d       = ch_idx;
    pix_d      = pix_idx;
    ch_last_d  = ch_last_q;
    pix_last_d = pix_last_q;

    case (state_q)
      IDLE: begin
        row_d = '0;
        ch_d  = '0;
        pix_d = '0;
        if (start) begin
          ch_last_d  = (cfg_channels == '0) ? '0 : (cfg_channels - CH_W'(1));
          pix_last_d = cfg_num_out - OUT_W'(1);
          state_d    = (cfg_num_out == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        row_d   = '0;
        ch_d    = '0;
        state_d = ACC;
      end
      ACC: begin
        if (in_valid) begin
          if (!row_wrap) begin
            row_d = row_idx + ROW_W'(1);
          end else begin
            row_d = '0;
            if (!ch_wrap) begin
              ch_d = ch_idx + CH_W'(1);
            end else begin
              ch_d = '0;
              if (pix_idx == pix_last_q) begin
                state_d = DONE;
              end else begin
                pix_d   = pix_idx + OUT_W'(1);
                state_d = CLEAR;
              end
            end
          end
        end
      end
      DONE: begin
        row_d   = '0;
        ch_d    = '0;
        pix_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pe_en_d    = (state_d != ACC);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    wgt_addr_d = ADDR_W'(ch_d) * ADDR_W'(KROWS) + ADDR_W'(row_d);
  end

  // State, index and registered-output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      row_idx    <= '0;
      ch_idx     <= '0;
      pix_idx    <= '0;
      ch_last_q  <= '0;
      pix_last_q <= '0;
      pe_en      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      wgt_addr   <= '0;
    end else begin
      state_q    <= state_d;
      row_idx    <= row_d;
      ch_idx     <= ch_d;
      pix_idx    <= pix_d;
      ch_last_q  <= ch_last_d;
      pix_last_q <= pix_last_d;
      pe_en      <= pe_en_d;
      busy       <= busy_d;
      done       <= done_d;
      wgt_addr   <= wgt_addr_d;
    end
  end

`ifdef PE_SEQ_CTRL_PERF_EN
  // Saturating count of ACC cycles spent waiting for operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if ((state_q == ACC) && !in_valid && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
